multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
Parametrised successor to the single-cycle CPU register file, for the pipelined and dual-issue cores. It provides N_READ combinational read ports and N_WRITE synchronous write ports, with a per-register busy scoreboard for hazard detection. A hardware clear sequencer walks every entry to zero after reset or on request, so storage can map to SRAM-style arrays without per-bit reset. Register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 32, width of each register in bits
DEPTH, 32, number of registers; must be a power of two and at least 2
N_READ, 2, number of read ports (1..4)
N_WRITE, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = entry 0 reads as zero, ignores writes and is never busy

Ports:
i_clk  in  1  clock; all state updates on its rising edge
i_arst  in  1  asynchronous, active-high reset
i_clear  in  1  single-cycle pulse that starts a clear sequence
o_ready  out  1  1 = file is usable; 0 while clearing
i_readAddress  in  N_READ x ADDR_W  read addresses; ADDR_W = $clog2(DEPTH)
o_readData  out  N_READ x DATA_W  read data
o_readBusy  out  N_READ  scoreboard busy bit of each addressed register
i_writeEnable  in  N_WRITE  per-port write enable
i_writeAddress  in  N_WRITE x ADDR_W  write addresses
i_writeData  in  N_WRITE x DATA_W  write data
i_setBusy  in  1  mark a register as having a pending producer
i_setBusyAddress  in  ADDR_W  register to mark busy

Behaviour:
- Clock i_clk only. Reset i_arst is asynchronous and active-high.
- Reset state:
  - FSM enters CLEAR with clear pointer 0.
  - o_ready = 0.
  - All busy bits = 0.
  - Storage array itself is not reset.
- FSM has two states, CLEAR and READY.
- CLEAR state:
  - Each cycle writes 0 to entry[pointer], then increments the pointer.
  - When pointer == DEPTH-1 is written, next state is READY and o_ready = 1 the following cycle.
  - A full clear therefore takes exactly DEPTH cycles after reset deassertion.
- READY state: i_clear=1 moves the FSM to CLEAR with pointer 0 and clears all busy bits on that edge.
- i_clear while already in CLEAR is ignored; the sequence is not restarted.
- i_arst asserted mid-clear restarts the sequence from pointer 0.
- While o_ready=0:
  - Port writes and i_setBusy are ignored.
  - o_readData reads as 0 and o_readBusy reads as 0.
- Reads:
  - Combinational: o_readData[r] = entry[i_readAddress[r]].
  - With ZERO_REG=1, address 0 returns 0.
  - Latency is 0 cycles.
- Writes:
  - Registered on the rising edge when i_writeEnable[w]=1 and o_ready=1.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Both ports writing the same address in the same cycle: the higher port index wins.
- Same-cycle read of an address being written returns the OLD value (unless the optional feature is enabled).
- Scoreboard:
  - A write on any port to address A clears busy[A].
  - i_setBusy to A sets busy[A].
  - Set and clear of the same A in one cycle: set wins, because the new producer supersedes the old one.
  - busy[0] stays 0 when ZERO_REG=1.
  - o_readBusy[r] = busy[i_readAddress[r]], combinational.
- Addresses are always in range because DEPTH is a power of two; there is no out-of-range handling.

Optional Feature:
REGFILE_WRITE_BYPASS_EN
- Defined:
  - A read whose address matches an enabled write in the same cycle returns that i_writeData, using the highest-index matching port.
  - The matching o_readBusy reads 0 unless i_setBusy targets the same address in that cycle.
  - Address 0 is still 0 when ZERO_REG=1.
  - Bypass is inactive while o_ready=0.
- Undefined: reads return the stored (old) value, and busy reflects the pre-edge state.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state enum (CLEAR, READY);
  - the function computing ADDR_W;
  - localparam limits MAX_READ=4 and MAX_WRITE=2.
- One sub-module, regfile_scoreboard, holds the DEPTH-bit busy vector, the set/clear priority logic and the N_READ lookup.
- Storage, write arbitration, the clear FSM and the bypass muxing stay in the top module.

Test Plan:
- Reset then idle (DEPTH=32) -> o_ready=0 for exactly 32 cycles after deassertion, then 1; every address reads 0.
- Write port0 A=5 D=0xDEADBEEF; next cycle read port1 A=5 -> 0xDEADBEEF.
  - Same-cycle read returns the old value with bypass undefined, and 0xDEADBEEF with REGFILE_WRITE_BYPASS_EN defined.
- Both ports write A=7, port0 D=0x11 and port1 D=0x22 -> A=7 reads 0x22; write A=0 D=0xFF -> A=0 reads 0.
- Scoreboard sequence:
  - setBusy A=9 -> o_readBusy=1 for A=9;
  - write A=9 together with setBusy A=9 -> busy stays 1;
  - write A=9 alone -> busy 0.
- i_clear in READY after filling entries with 0xA5A5A5A5:
  - o_ready drops next cycle and busy clears;
  - writes during the clear are ignored;
  - after 32 cycles all entries read 0.
- Assert i_arst at pointer 12 mid-clear -> after deassertion o_ready stays low for a full 32 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and sizing helpers for the multiport register file
//
// Contents:
//   MAX_READ / MAX_WRITE : largest supported read / write port counts
//   state_e              : clear-sequencer states (ST_CLEAR, ST_READY)
//   addr_w()             : address width for a given DEPTH
package regfile_pkg;

  localparam int MAX_READ  = 4;
  localparam int MAX_WRITE = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with set/clear priority and read lookup
//
// Ports:
//   i_clk, i_arst     : clock, asynchronous active-high reset (all busy bits cleared)
//   i_flush           : synchronous clear of every busy bit
//   i_clrEnable/Addr  : per write port, clear busy of the written register
//   i_setEnable/Addr  : mark one register busy (wins over a same-cycle clear)
//   i_readAddress     : per read port lookup address
//   o_readBusy        : busy bit of each looked-up register (combinational)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int N_READ   = 2,
  parameter int N_WRITE  = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic                           i_flush,
  input  logic [N_WRITE-1:0]             i_clrEnable,
  input  logic [N_WRITE-1:0][ADDR_W-1:0] i_clrAddress,
  input  logic                           i_setEnable,
  input  logic [ADDR_W-1:0]              i_setAddress,
  input  logic [N_READ-1:0][ADDR_W-1:0]  i_readAddress,
  output logic [N_READ-1:0]              o_readBusy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < N_WRITE; w++) begin
      if (i_clrEnable[w]) busy_d[i_clrAddress[w]] = 1'b0;
    end
    // A new producer supersedes the one that is retiring this cycle.
    if (i_setEnable) busy_d[i_setAddress] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
    if (i_flush) busy_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    for (int r = 0; r < N_READ; r++) begin
      o_readBusy[r] = busy_q[i_readAddress[r]];
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - N_READ/N_WRITE register file with busy scoreboard and clear sequencer
//
// Optional macro: REGFILE_WRITE_BYPASS_EN (same-cycle write-to-read forwarding)
//
// Ports:
//   i_clk, i_arst       : clock, asynchronous active-high reset (restarts the clear walk)
//   i_clear             : pulse in READY starts a new clear walk and flushes busy bits
//   o_ready             : 1 once every entry has been zeroed
//   i_readAddress       : N_READ read addresses
//   o_readData          : N_READ combinational read data (0 while not ready)
//   o_readBusy          : N_READ busy bits of the addressed registers (0 while not ready)
//   i_writeEnable/Address/Data : N_WRITE write ports, higher index wins on collision
//   i_setBusy/Address   : mark a register as having a pending producer
// ADDR_W is derived from DEPTH and is not meant to be overridden.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int N_READ   = 2,
  parameter int N_WRITE  = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic                           i_clear,
  output logic                           o_ready,
  input  logic [N_READ-1:0][ADDR_W-1:0]  i_readAddress,
  output logic [N_READ-1:0][DATA_W-1:0]  o_readData,
  output logic [N_READ-1:0]              o_readBusy,
  input  logic [N_WRITE-1:0]             i_writeEnable,
  input  logic [N_WRITE-1:0][ADDR_W-1:0] i_writeAddress,
  input  logic [N_WRITE-1:0][DATA_W-1:0] i_writeData,
  input  logic                           i_setBusy,
  input  logic [ADDR_W-1:0]              i_setBusyAddress
);

  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                ready;
  logic [N_READ-1:0]   sb_busy;
  logic [N_WRITE-1:0]  wr_en;

  assign ready   = (state_q == ST_READY);
  assign o_ready = ready;

  // Port writes only take effect once the file is usable.
  always_comb begin
    for (int w = 0; w < N_WRITE; w++) begin
      wr_en[w] = i_writeEnable[w] && ready;
    end
  end

  // Clear sequencer: walk every entry once, then hand over to READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage has no reset so it can map onto an SRAM-style array; the
  // sequencer provides the zero state instead. Later ports overwrite
  // earlier ones in the loop, giving the higher index priority.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int w = 0; w < N_WRITE; w++) begin
        if (i_writeEnable[w] && !(ZERO_REG && (i_writeAddress[w] == '0))) begin
          mem_q[i_writeAddress[w]] <= i_writeData[w];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .N_READ   (N_READ),
    .N_WRITE  (N_WRITE),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_flush       (ready && i_clear),
    .i_clrEnable   (wr_en),
    .i_clrAddress  (i_writeAddress),
    .i_setEnable   (i_setBusy && ready),
    .i_setAddress  (i_setBusyAddress),
    .i_readAddress (i_readAddress),
    .o_readBusy    (sb_busy)
  );

  always_comb begin
    for (int r = 0; r < N_READ; r++) begin
      o_readData[r] = mem_q[i_readAddress[r]];
      o_readBusy[r] = sb_busy[r];
`ifdef REGFILE_WRITE_BYPASS_EN
      // Forward same-cycle write data; the write retires the producer, so
      // busy drops unless a new producer is claimed on the same edge.
      for (int w = 0; w < N_WRITE; w++) begin
        if (wr_en[w] && (i_writeAddress[w] == i_readAddress[r])) begin
          o_readData[r] = i_writeData[w];
          o_readBusy[r] = i_setBusy && (i_setBusyAddress == i_readAddress[r]);
        end
      end
`endif
      if (!ready || (ZERO_REG && (i_readAddress[r] == '0))) begin
        o_readData[r] = '0;
        o_readBusy[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - self-checking bench for multiport_register_file
module tb_multiport_register_file;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              busy;
  } exp_t;

  logic                  clk;
  logic                  arst;
  logic                  clear;
  logic                  ready;
  logic [1:0][AW-1:0]    raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]            rbusy;
  logic [1:0]            we;
  logic [1:0][AW-1:0]    waddr;
  logic [1:0][DATA_W-1:0] wdata;
  logic                  set_busy;
  logic [AW-1:0]         set_addr;

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  multiport_register_file #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .N_READ   (2),
    .N_WRITE  (2),
    .ZERO_REG (1'b1)
  ) dut (
    .i_clk            (clk),
    .i_arst           (arst),
    .i_clear          (clear),
    .o_ready          (ready),
    .i_readAddress    (raddr),
    .o_readData       (rdata),
    .o_readBusy       (rbusy),
    .i_writeEnable    (we),
    .i_writeAddress   (waddr),
    .i_writeData      (wdata),
    .i_setBusy        (set_busy),
    .i_setBusyAddress (set_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear    = 1'b0;
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    set_busy = 1'b0;
    set_addr = '0;
  endtask

  task automatic test_reset();
    int   cycles;
    exp_t e;
    idle_inputs();
    raddr = '0;
    arst  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b expected 0", ready);
    end
    arst = 1'b0;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != DEPTH) begin
      n_fail++;
      $display("FAIL reset_clear_len: got %0d cycles expected %0d", cycles, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      raddr[0] = AW'(a);
      raddr[1] = AW'(DEPTH - 1 - a);
      exp_q.push_back('{data: '0, busy: 1'b0});
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (rdata[0] !== e.data || rdata[1] !== e.data || rbusy !== {2{e.busy}}) begin
        n_fail++;
        $display("FAIL reset_read a=%0d: got %h/%h busy %b expected %h busy %b",
                 a, rdata[0], rdata[1], rbusy, e.data, e.busy);
      end
    end
  endtask

  task automatic test_write();
    exp_t e;
    idle_inputs();
    we[0]    = 1'b1;
    waddr[0] = 5'd5;
    wdata[0] = 32'hDEADBEEF;
    raddr[1] = 5'd5;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_q.push_back('{data: 32'hDEADBEEF, busy: 1'b0});
`else
    exp_q.push_back('{data: 32'h0, busy: 1'b0});
`endif
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (rdata[1] !== e.data) begin
      n_fail++;
      $display("FAIL write_same_cycle: got %h expected %h", rdata[1], e.data);
    end
    tick();
    idle_inputs();
    exp_q.push_back('{data: 32'hDEADBEEF, busy: 1'b0});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (rdata[1] !== e.data || rbusy[1] !== e.busy) begin
      n_fail++;
      $display("FAIL write_next_cycle: got %h busy %b expected %h busy %b",
               rdata[1], rbusy[1], e.data, e.busy);
    end
  endtask

  task automatic test_collision_zero();
    exp_t e;
    idle_inputs();
    we       = 2'b11;
    waddr[0] = 5'd7;
    waddr[1] = 5'd7;
    wdata[0] = 32'h11;
    wdata[1] = 32'h22;
    tick();
    idle_inputs();
    we[1]    = 1'b1;
    waddr[1] = 5'd0;
    wdata[1] = 32'hFF;
    set_busy = 1'b1;
    set_addr = 5'd0;
    tick();
    idle_inputs();
    raddr[0] = 5'd7;
    raddr[1] = 5'd0;
    exp_q.push_back('{data: 32'h22, busy: 1'b0});
    exp_q.push_back('{data: 32'h0, busy: 1'b0});
    #1;
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rdata[p] !== e.data || rbusy[p] !== e.busy) begin
        n_fail++;
        $display("FAIL collision_zero port%0d: got %h busy %b expected %h busy %b",
                 p, rdata[p], rbusy[p], e.data, e.busy);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    idle_inputs();
    raddr[0] = 5'd9;
    raddr[1] = 5'd10;
    set_busy = 1'b1;
    set_addr = 5'd9;
    tick();
    idle_inputs();
    exp_q.push_back('{data: '0, busy: 1'b1});
    exp_q.push_back('{data: '0, busy: 1'b0});
    #1;
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rbusy[p] !== e.busy) begin
        n_fail++;
        $display("FAIL sb_set port%0d: got %b expected %b", p, rbusy[p], e.busy);
      end
    end
    we[0]    = 1'b1;
    waddr[0] = 5'd9;
    wdata[0] = 32'h99;
    set_busy = 1'b1;
    set_addr = 5'd9;
    tick();
    idle_inputs();
    exp_q.push_back('{data: 32'h99, busy: 1'b1});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (rdata[0] !== e.data || rbusy[0] !== e.busy) begin
      n_fail++;
      $display("FAIL sb_set_wins: got %h busy %b expected %h busy %b",
               rdata[0], rbusy[0], e.data, e.busy);
    end
    we[1]    = 1'b1;
    waddr[1] = 5'd9;
    wdata[1] = 32'h98;
    tick();
    idle_inputs();
    exp_q.push_back('{data: 32'h98, busy: 1'b0});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (rdata[0] !== e.data || rbusy[0] !== e.busy) begin
      n_fail++;
      $display("FAIL sb_write_clears: got %h busy %b expected %h busy %b",
               rdata[0], rbusy[0], e.data, e.busy);
    end
  endtask

  task automatic test_clear();
    int   cycles;
    exp_t e;
    idle_inputs();
    for (int a = 1; a < DEPTH; a += 2) begin
      we       = 2'b11;
      waddr[0] = AW'(a);
      waddr[1] = AW'((a + 1) % DEPTH);
      wdata    = {2{32'hA5A5A5A5}};
      tick();
    end
    idle_inputs();
    set_busy = 1'b1;
    set_addr = 5'd3;
    tick();
    idle_inputs();
    raddr[0] = 5'd3;
    raddr[1] = 5'd31;
    exp_q.push_back('{data: 32'hA5A5A5A5, busy: 1'b1});
    exp_q.push_back('{data: 32'hA5A5A5A5, busy: 1'b0});
    #1;
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rdata[p] !== e.data || rbusy[p] !== e.busy) begin
        n_fail++;
        $display("FAIL clear_fill port%0d: got %h busy %b expected %h busy %b",
                 p, rdata[p], rbusy[p], e.data, e.busy);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready_drop: got %b expected 0", ready);
    end
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      we       = 2'b11;
      waddr[0] = 5'd4;
      waddr[1] = AW'(cycles);
      wdata    = {32'h1234, 32'h5678};
      set_busy = 1'b1;
      set_addr = 5'd4;
      tick();
      cycles++;
    end
    idle_inputs();
    n_checks++;
    if (cycles != DEPTH) begin
      n_fail++;
      $display("FAIL clear_len: got %0d cycles expected %0d", cycles, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      raddr[0] = AW'(a);
      raddr[1] = AW'(a);
      exp_q.push_back('{data: '0, busy: 1'b0});
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (rdata[0] !== e.data || rbusy[0] !== e.busy) begin
        n_fail++;
        $display("FAIL clear_read a=%0d: got %h busy %b expected %h busy %b",
                 a, rdata[0], rbusy[0], e.data, e.busy);
      end
    end
  endtask

  task automatic test_arst_mid_clear();
    int cycles;
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_mid_pre: got %b expected 0", ready);
    end
    arst = 1'b1;
    #2;
    arst = 1'b0;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != DEPTH) begin
      n_fail++;
      $display("FAIL arst_mid_len: got %0d cycles expected %0d", cycles, DEPTH);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst     = 1'b0;
    raddr    = '0;
    idle_inputs();
    #1;
    test_reset();
    test_write();
    test_collision_zero();
    test_scoreboard();
    test_clear();
    test_arst_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
